// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared definitions for the FIFO pop controller: controller state encoding
// and the default FIFO word width.
package fifo_pop_ctrl_pkg;

   localparam int DefaultDataWidth = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      ERR   = 2'd3
   } state_e;

endpackage

// File: rtl/fifo_pop_ctrl_skid_buf2.sv
// Two-entry in-order skid buffer that holds words popped from the FIFO until
// downstream accepts them. The flush input empties it without touching the data.
module skid_buf2 #(
   parameter int data_width = 6
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [data_width-1:0] din,
   output logic [data_width-1:0] dout,
   output logic [1:0]            occ
);

   logic [data_width-1:0] head_q;
   logic [data_width-1:0] tail_q;
   logic [1:0]            occ_q;
   logic                  doPop;

   assign doPop = pop && (occ_q != 2'd0);
   assign dout  = head_q;
   assign occ   = occ_q;

   // Head always holds the oldest word; a pop shifts the tail forward.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else if (flush) begin
         occ_q <= 2'd0;
      end else begin
         case ({push, doPop})
            2'b10: begin
               if (occ_q == 2'd0) head_q <= din;
               else               tail_q <= din;
               if (occ_q != 2'd2) occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  head_q <= din;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

   overflowCheck: assert property (@(posedge clk) disable iff (!reset_L)
      !(push && !flush && !doPop && (occ_q == 2'd2)));

endmodule

// File: rtl/fifo_pop_ctrl.sv
// FIFO pop controller: issues pop strobes to a FIFO, absorbs the one-cycle read
// latency in a 2-entry skid buffer and streams words out with valid/ready.
module fifo_pop_ctrl
   import fifo_pop_ctrl_pkg::*;
#(
   parameter int data_width = DefaultDataWidth,
   parameter int cnt_width  = 8
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_error,
   input  logic [data_width-1:0] fifo_data,
   output logic                  fifo_rd_enable,
   input  logic                  ready_in,
   output logic                  valid_out,
   output logic [data_width-1:0] data_out,
   output logic                  busy,
   output logic                  error_out,
   output logic [cnt_width-1:0]  word_count
);

   state_e                state_q;
   state_e                state_d;
   logic                  inflight_q;
   logic [cnt_width-1:0]  count_q;
   logic [cnt_width-1:0]  count_d;
   logic [1:0]            occ;
   logic [data_width-1:0] headWord;
   logic                  pop;
   logic                  flush;
   logic [2:0]            pending;

   // Words already committed to the buffer after this edge; keeping it below two
   // guarantees the word returned next cycle always has a free slot.
   assign pending        = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd_enable = (state_q == RUN) && !fifo_empty && (pending < 3'd2);

   assign flush      = (state_q == ERR);
   assign valid_out  = (occ != 2'd0) && !flush;
   assign pop        = valid_out && ready_in;
   assign data_out   = valid_out ? headWord : '0;
   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign error_out  = flush;
   assign word_count = count_q;
   assign count_d    = count_q + {{(cnt_width-1){1'b0}}, pop};

   skid_buf2 #(
      .data_width(data_width)
   ) uBuf (
      .clk     (clk),
      .reset_L (reset_L),
      .flush   (flush),
      .push    (inflight_q),
      .pop     (pop),
      .din     (fifo_data),
      .dout    (headWord),
      .occ     (occ)
   );

   always_comb begin
      state_d = state_q;
      if (fifo_error) begin
         state_d = ERR;
      end else begin
         case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
               if (enable)                               state_d = RUN;
               else if (!inflight_q && (occ == 2'd0))    state_d = IDLE;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= fifo_rd_enable;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Self-checking bench for fifo_pop_ctrl: a behavioural FIFO feeds the DUT and a
// word-accounting reference model predicts every output each cycle.
module tb_fifo_pop_ctrl;

   localparam int MsIdle  = 0;
   localparam int MsRun   = 1;
   localparam int MsDrain = 2;
   localparam int MsErr   = 3;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       enable = 1'b0;
   logic       fifo_empty;
   logic       fifo_error = 1'b0;
   logic [5:0] fifo_data;
   logic       fifo_rd_enable;
   logic       ready_in = 1'b0;
   logic       valid_out;
   logic [5:0] data_out;
   logic       busy;
   logic       error_out;
   logic [7:0] word_count;

   int numChecks = 0;
   int numFails  = 0;

   logic [5:0] loadQ[$];
   logic [5:0] expQ[$];
   int         rdPtr = 0;

   int mState, outstanding, prevRd, delivered, rdSeen, cyc;
   logic       sValid, sRd, sBusy, sErr;
   logic [5:0] sData;
   logic [7:0] sCount;
   int firstRd, firstValid;

   always #5 clk = ~clk;

   fifo_pop_ctrl dut (
      .clk            (clk),
      .reset_L        (reset_L),
      .enable         (enable),
      .fifo_empty     (fifo_empty),
      .fifo_error     (fifo_error),
      .fifo_data      (fifo_data),
      .fifo_rd_enable (fifo_rd_enable),
      .ready_in       (ready_in),
      .valid_out      (valid_out),
      .data_out       (data_out),
      .busy           (busy),
      .error_out      (error_out),
      .word_count     (word_count)
   );

   // FIFO with registered empty flag; read data appears the cycle after the strobe.
   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rdPtr      <= loadQ.size();
         fifo_data  <= '0;
         fifo_empty <= 1'b1;
      end else if (fifo_rd_enable && (rdPtr < loadQ.size())) begin
         fifo_data  <= loadQ[rdPtr];
         rdPtr      <= rdPtr + 1;
         fifo_empty <= ((rdPtr + 1) == loadQ.size());
      end else begin
         fifo_data  <= '0;
         fifo_empty <= (rdPtr == loadQ.size());
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      numChecks++;
      if (observed !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic loadWord(input logic [5:0] w);
      loadQ.push_back(w);
      expQ.push_back(w);
   endtask

   // Called at a negedge with inputs already driven; checks this cycle, advances the model.
   task automatic applyStimulus();
      int  nextState;
      int  outBefore;
      logic validExp, popExp, rdExp;
      #1;
      sValid = valid_out; sData = data_out; sRd = fifo_rd_enable;
      sBusy = busy; sErr = error_out; sCount = word_count;
      validExp = (mState != MsErr) && ((outstanding - prevRd) > 0);
      popExp   = validExp && ready_in;
      rdExp    = (mState == MsRun) && !fifo_empty && ((outstanding - int'(popExp)) < 2);
      checkOutput("valid_out", int'(sValid), int'(validExp));
      checkOutput("fifo_rd_enable", int'(sRd), int'(rdExp));
      checkOutput("busy", int'(sBusy), int'((mState == MsRun) || (mState == MsDrain)));
      checkOutput("error_out", int'(sErr), int'(mState == MsErr));
      checkOutput("word_count", int'(sCount), delivered % 256);
      if (!validExp)            checkOutput("data_out_idle", int'(sData), 0);
      else if (expQ.size() > 0) checkOutput("data_out", int'(sData), int'(expQ[0]));
      if (popExp && (expQ.size() > 0)) begin
         void'(expQ.pop_front());
         delivered++;
      end
      outBefore   = outstanding;
      outstanding = outstanding + int'(rdExp) - int'(popExp);
      rdSeen      = rdSeen + int'(sRd);
      nextState   = mState;
      if (fifo_error) nextState = MsErr;
      else case (mState)
         MsIdle:  if (enable) nextState = MsRun;
         MsRun:   if (!enable) nextState = MsDrain;
         MsDrain: if (enable) nextState = MsRun; else if (outBefore == 0) nextState = MsIdle;
         default: nextState = mState;
      endcase
      if ((nextState == MsErr) && (mState != MsErr)) begin
         repeat (outstanding) if (expQ.size() > 0) void'(expQ.pop_front());
         outstanding = 0;
      end
      mState = nextState;
      prevRd = int'(rdExp);
      cyc++;
      @(negedge clk);
   endtask

   task automatic doReset();
      enable = 1'b0; ready_in = 1'b0; fifo_error = 1'b0;
      reset_L = 1'b0;
      #1;
      checkOutput("rst_valid", int'(valid_out), 0);
      checkOutput("rst_data", int'(data_out), 0);
      checkOutput("rst_rd", int'(fifo_rd_enable), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_err", int'(error_out), 0);
      checkOutput("rst_count", int'(word_count), 0);
      repeat (2) @(negedge clk);
      mState = MsIdle; outstanding = 0; prevRd = 0; delivered = 0;
      rdSeen = 0; cyc = 0; sValid = 1'b0;
      expQ.delete();
      reset_L = 1'b1;
   endtask

   initial begin
      @(negedge clk);

      // Three preloaded words stream out back to back.
      doReset();
      loadWord(6'h01); loadWord(6'h02); loadWord(6'h03);
      enable = 1'b1; ready_in = 1'b1;
      firstRd = -1; firstValid = -1;
      for (int i = 0; (i < 20) && (firstValid < 0); i++) begin
         applyStimulus();
         if (sRd && (firstRd < 0)) firstRd = cyc - 1;
         if (sValid) firstValid = cyc - 1;
      end
      checkOutput("A_latency", firstValid - firstRd, 2);
      checkOutput("A_word1", int'(sData), 'h01);
      applyStimulus();
      checkOutput("A_word2", int'(sData), 'h02);
      applyStimulus();
      checkOutput("A_word3", int'(sData), 'h03);
      applyStimulus();
      checkOutput("A_empty_valid", int'(sValid), 0);
      checkOutput("A_count", int'(sCount), 3);
      checkOutput("A_no_read", int'(sRd), 0);
      checkOutput("A_still_busy", int'(sBusy), 1);

      // Downstream stalls: reads stop once two words are committed.
      doReset();
      for (int i = 0; i < 4; i++) loadWord(6'(8'h10 + i));
      enable = 1'b1;
      for (int i = 0; (i < 20) && !sValid; i++) applyStimulus();
      repeat (4) applyStimulus();
      checkOutput("B_reads_stalled", rdSeen, 2);
      checkOutput("B_head_held", int'(sData), 'h10);
      ready_in = 1'b1;
      repeat (10) applyStimulus();
      checkOutput("B_count", int'(sCount), 4);
      checkOutput("B_reads_total", rdSeen, 4);

      // Enable dropped right after the first read issues.
      doReset();
      loadWord(6'h21); loadWord(6'h22); loadWord(6'h23);
      enable = 1'b1; ready_in = 1'b1;
      for (int i = 0; (i < 20) && !sRd; i++) applyStimulus();
      enable = 1'b0;
      repeat (10) applyStimulus();
      checkOutput("C_reads", rdSeen, 2);
      checkOutput("C_count", int'(sCount), 2);
      checkOutput("C_idle", int'(sBusy), 0);
      checkOutput("C_no_read", int'(sRd), 0);

      // Error pulse during RUN is sticky until reset.
      doReset();
      for (int i = 0; i < 5; i++) loadWord(6'(8'h30 + i));
      enable = 1'b1; ready_in = 1'b1;
      repeat (4) applyStimulus();
      fifo_error = 1'b1;
      applyStimulus();
      fifo_error = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("D_err_held", int'(sErr), 1);
         checkOutput("D_no_valid", int'(sValid), 0);
      end
      doReset();

      // Reset with a full buffer discards everything.
      for (int i = 0; i < 4; i++) loadWord(6'(8'h05 + i));
      enable = 1'b1;
      repeat (6) applyStimulus();
      checkOutput("E_full_valid", int'(sValid), 1);
      doReset();
      enable = 1'b1; ready_in = 1'b1;
      applyStimulus();
      checkOutput("E_no_word", int'(sValid), 0);

      // Counter wrap plus one-word-per-cycle throughput.
      doReset();
      for (int i = 0; i < 256; i++) loadWord(6'(i));
      enable = 1'b1; ready_in = 1'b1;
      for (int i = 0; (i < 400) && (delivered < 255); i++) applyStimulus();
      checkOutput("G_throughput", cyc, 258);
      applyStimulus();
      checkOutput("G_count_ff", int'(sCount), 'hFF);
      applyStimulus();
      checkOutput("G_count_wrap", int'(sCount), 'h00);

      // Randomized traffic against the reference model.
      doReset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) loadWord(6'($urandom_range(0, 63)));
         if ($urandom_range(0, 9) == 0) enable = ~enable;
         ready_in = ($urandom_range(0, 9) < 7);
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/fifo_pop_ctrl.md
FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 Parameter data_width, default 6, FIFO word width in bits.
REQ-002 Parameter cnt_width, default 8, width of delivered-word counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports named clk and reset_L.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  request to stream words out of the FIFO.
REQ-007 fifo_empty  input  1  FIFO empty flag (registered in FIFO).
REQ-008 fifo_error  input  1  FIFO overflow/underflow flag.
REQ-009 fifo_data  input  data_width  FIFO read data, valid one cycle after fifo_rd_enable, zero otherwise.
REQ-010 fifo_rd_enable  output  1  pop strobe to FIFO.
REQ-011 ready_in  input  1  downstream accepts data_out this cycle.
REQ-012 valid_out  output  1  data_out holds a valid word.
REQ-013 data_out  output  data_width  head word of internal buffer; zero when valid_out=0.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 error_out  output  1  sticky error indication.
REQ-016 word_count  output  cnt_width  number of words delivered (valid_out&&ready_in), wraps.

Function
REQ-017 The block SHALL have states IDLE, RUN, DRAIN, ERR.
REQ-018 IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->RUN when enable=1; DRAIN->IDLE when enable=0, no read in flight and buffer empty.
REQ-019 Any state->ERR when fifo_error=1; ERR SHALL be left only by reset; ERR overrides all other transitions.
REQ-020 fifo_rd_enable SHALL be combinational: state==RUN && !fifo_empty && (occ - pop + inflight) < 2, where occ = buffer occupancy (0..2), pop = valid_out&&ready_in, inflight = read issued previous cycle.
REQ-021 inflight SHALL be registered as fifo_rd_enable; when inflight=1 fifo_data SHALL be written into the buffer tail on the next edge.
REQ-022 Buffer SHALL be a 2-entry in-order skid buffer; simultaneous push and pop SHALL keep occ unchanged and preserve order.
REQ-023 valid_out SHALL equal (occ != 0); data_out SHALL be the buffer head.
REQ-024 With ready_in held high, enable=1 and FIFO non-empty, throughput SHALL be one word per cycle; first word latency from fifo_rd_enable to valid_out = 2 edges.
REQ-025 The buffer SHALL never overflow; a push with occ==2 and no pop is a design error (assertion).
REQ-026 In DRAIN no new reads SHALL issue; the in-flight word and buffered words SHALL still be delivered.
REQ-027 In ERR fifo_rd_enable=0, valid_out=0, data_out=0, buffer contents discarded, error_out=1.
REQ-028 word_count SHALL increment by 1 per pop, modulo 2^cnt_width.

Reset
REQ-029 While reset_L=0: state=IDLE, occ=0, inflight=0, word_count=0, error_out=0, valid_out=0, data_out=0, busy=0, fifo_rd_enable=0.
REQ-030 Reset asserted mid-transfer SHALL discard buffered and in-flight words; no word SHALL be delivered on the first edge after release.

Structure
REQ-031 Shared package SHALL hold state encoding constants (IDLE, RUN, DRAIN, ERR, 2-bit) and default data_width.
REQ-032 Skid buffer SHALL be a sub-module skid_buf2 (push, pop, din, dout, occ), same clk/reset_L.

Verification
REQ-033 FIFO preloaded 0x01,0x02,0x03, enable=1, ready_in=1 -> data_out 0x01,0x02,0x03 on consecutive cycles, word_count=3, then DRAIN-free stall with fifo_rd_enable=0.
REQ-034 4 words, ready_in low 5 cycles after first valid -> exactly 2 reads issued, occ=2, no loss/reorder after ready_in rises.
REQ-035 enable dropped the cycle after a read issues -> that word plus buffered words delivered, state returns to IDLE, no further fifo_rd_enable.
REQ-036 fifo_error pulsed 1 cycle during RUN -> ERR, error_out=1 held, valid_out=0 until reset_L pulse.
REQ-037 word_count at 0xFF, one pop -> 0x00.
REQ-038 reset_L asserted with occ=2 -> all outputs zero immediately (asynchronously), occ=0 after release.
